// File: rtl/part2_drv_pkg.sv
// Shared types and constants for the part-2 write-channel driver.
package part2_drv_pkg;

  localparam int NUM_CHAN = 3;

  typedef logic [1:0] chan_t;
  typedef logic [7:0] byte_t;
  typedef enum {IDLE, WAIT} emit_state_t;

  // Channel tag that is consumed and discarded instead of being buffered.
  localparam chan_t ILLEGAL_CHAN = 2'd3;

endpackage

// File: rtl/part2_chan_fifo.sv
// Per-channel byte FIFO with registered head; push is ignored when full and
// pop is ignored when empty, and full is never relieved by a same-edge pop.
module part2_chan_fifo
  import part2_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output byte_t head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  byte_t       mem_q [DEPTH];

  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // validity, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/part2_wen_driver.sv
// Channel-tagged byte stream to three registered write strobes with an
// optional per-channel gap. Strobe counters exist with PART2_WEN_DRIVER_STATS_EN.
module part2_wen_driver
  import part2_drv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_chan,
  input  logic [7:0]  in_data,
  input  logic        freeze,
  output logic        wen0,
  output logic        wen1,
  output logic        wen2,
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic        drop_err
`ifdef PART2_WEN_DRIVER_STATS_EN
  ,
  output logic [15:0] wr_count0,
  output logic [15:0] wr_count1,
  output logic [15:0] wr_count2
`endif
);

  logic [NUM_CHAN-1:0] fifo_full, fifo_empty, push, pop, wen;
  logic [3:0]          full_ext;
  byte_t               head [NUM_CHAN];
  byte_t               data [NUM_CHAN];
  logic                accept;
  logic                drop_err_q;

  // Pad to four entries so the illegal tag indexes a defined bit.
  assign full_ext = {1'b0, fifo_full};

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    in_ready = 1'b1;
    if (in_chan != ILLEGAL_CHAN) in_ready = !full_ext[in_chan];
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) drop_err_q <= 1'b0;
    else       drop_err_q <= accept && (in_chan == ILLEGAL_CHAN);
  end

  assign drop_err = drop_err_q;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    emit_state_t state_q, state_d;
    logic [3:0]  gap_q, gap_d;
    logic        wen_q;
    byte_t       data_q;

    assign push[c] = accept && (in_chan == chan_t'(c));

    part2_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[c]),
      .push_data (in_data),
      .pop       (pop[c]),
      .full      (fifo_full[c]),
      .empty     (fifo_empty[c]),
      .head      (head[c])
    );

    assign pop[c] = (state_q == IDLE) && !fifo_empty[c] && !freeze;

    // The gap counter keeps running through freeze; freeze only gates pops.
    always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
        IDLE: begin
          if (pop[c] && (GAP != 0)) begin
            state_d = WAIT;
            gap_d   = 4'(GAP);
          end
        end
        WAIT: begin
          gap_d = gap_q - 4'd1;
          if (gap_q <= 4'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        gap_q   <= 4'd0;
        wen_q   <= 1'b0;
        data_q  <= 8'h00;
      end else begin
        state_q <= state_d;
        gap_q   <= gap_d;
        wen_q   <= pop[c];
        if (pop[c]) data_q <= head[c];
      end
    end

    assign wen[c]  = wen_q;
    assign data[c] = data_q;

`ifdef PART2_WEN_DRIVER_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
      if (reset)      count_q <= 16'h0000;
      else if (wen_q) count_q <= count_q + 16'd1;
    end
`endif
  end

  assign wen0  = wen[0];
  assign wen1  = wen[1];
  assign wen2  = wen[2];
  assign data0 = data[0];
  assign data1 = data[1];
  assign data2 = data[2];

`ifdef PART2_WEN_DRIVER_STATS_EN
  assign wr_count0 = g_chan[0].count_q;
  assign wr_count1 = g_chan[1].count_q;
  assign wr_count2 = g_chan[2].count_q;
`endif

endmodule

// File: tb/tb_part2_wen_driver.sv
// Directed self-checking bench: one DUT with GAP=0 for most scenarios and a
// second with GAP=2 for strobe spacing. Stats scenario needs PART2_WEN_DRIVER_STATS_EN.
module tb_part2_wen_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, freeze, in_ready, drop_err;
  logic [1:0] in_chan;
  logic [7:0] in_data;
  logic       wen0, wen1, wen2;
  logic [7:0] data0, data1, data2;

  logic       g_valid, g_ready, g_drop;
  logic [1:0] g_chan;
  logic [7:0] g_data;
  logic       g_wen0, g_wen1, g_wen2;
  logic [7:0] g_data0, g_data1, g_data2;

`ifdef PART2_WEN_DRIVER_STATS_EN
  logic [15:0] wr_count0, wr_count1, wr_count2;
  logic [15:0] g_cnt0, g_cnt1, g_cnt2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  part2_wen_driver #(.DEPTH(4), .GAP(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_chan  (in_chan),
    .in_data  (in_data),
    .freeze   (freeze),
    .wen0     (wen0),
    .wen1     (wen1),
    .wen2     (wen2),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .drop_err (drop_err)
`ifdef PART2_WEN_DRIVER_STATS_EN
    ,
    .wr_count0 (wr_count0),
    .wr_count1 (wr_count1),
    .wr_count2 (wr_count2)
`endif
  );

  part2_wen_driver #(.DEPTH(4), .GAP(2)) dut_gap (
    .clk      (clk),
    .reset    (reset),
    .in_valid (g_valid),
    .in_ready (g_ready),
    .in_chan  (g_chan),
    .in_data  (g_data),
    .freeze   (1'b0),
    .wen0     (g_wen0),
    .wen1     (g_wen1),
    .wen2     (g_wen2),
    .data0    (g_data0),
    .data1    (g_data1),
    .data2    (g_data2),
    .drop_err (g_drop)
`ifdef PART2_WEN_DRIVER_STATS_EN
    ,
    .wr_count0 (g_cnt0),
    .wr_count1 (g_cnt1),
    .wr_count2 (g_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_wen [4];
    logic       exp_gap [8];

    reset = 1'b1; in_valid = 1'b0; in_chan = 2'd0; in_data = 8'h00; freeze = 1'b0;
    g_valid = 1'b0; g_chan = 2'd2; g_data = 8'h00;
    tick();
    check("rst_wen",   {wen2, wen1, wen0}, 3'b000);
    check("rst_data0", data0, 8'h00);
    check("rst_data1", data1, 8'h00);
    check("rst_data2", data2, 8'h00);
    check("rst_drop",  drop_err, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_ready", in_ready, 1'b1);

    // Basic: one byte on chan 1, strobe two edges after acceptance.
    in_valid = 1'b1; in_chan = 2'd1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("basic_k", {wen2, wen1, wen0}, 3'b000);
    tick();
    check("basic_wen",   {wen2, wen1, wen0}, 3'b010);
    check("basic_data1", data1, 8'hA5);
    tick();
    check("basic_off",  {wen2, wen1, wen0}, 3'b000);
    check("basic_hold", data1, 8'hA5);

    // Full: freeze, fill chan 0, fifth byte must be refused.
    freeze = 1'b1; in_valid = 1'b1; in_chan = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      #1;
      check("full_ready_lo_fill", in_ready, 1'b1);
      tick();
    end
    in_data = 8'h05;
    #1;
    check("full_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    check("full_frozen", {wen2, wen1, wen0}, 3'b000);
    tick();
    check("full_frozen2", wen0, 1'b0);
    freeze = 1'b0;
    tick();
    check("full_s1_wen",  wen0, 1'b1);
    check("full_s1_data", data0, 8'h01);
    check("full_ready_back", in_ready, 1'b1);
    tick();
    check("full_s2_wen",  wen0, 1'b1);
    check("full_s2_data", data0, 8'h02);
    tick();
    check("full_s3_wen",  wen0, 1'b1);
    check("full_s3_data", data0, 8'h03);
    tick();
    check("full_s4_wen",  wen0, 1'b1);
    check("full_s4_data", data0, 8'h04);
    tick();
    check("full_done", wen0, 1'b0);
    check("full_hold", data0, 8'h04);

    // Gap: three bytes on chan 2 of the GAP=2 instance.
    exp_gap = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    g_valid = 1'b1; g_data = 8'h11;
    tick();
    for (int i = 0; i < 8; i++) begin
      g_data = (i == 0) ? 8'h22 : 8'h33;
      g_valid = (i < 2);
      tick();
      check($sformatf("gap_wen2_%0d", i), g_wen2, exp_gap[i]);
      check($sformatf("gap_others_%0d", i), {g_wen1, g_wen0}, 2'b00);
      if (i == 0) check("gap_d0", g_data2, 8'h11);
      if (i == 3) check("gap_d1", g_data2, 8'h22);
      if (i == 6) check("gap_d2", g_data2, 8'h33);
    end
    g_valid = 1'b0;

    // Illegal channel: consumed, drop_err pulses once, no strobes.
    in_valid = 1'b1; in_chan = 2'd3; in_data = 8'hFF;
    #1;
    check("ill_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("ill_drop", drop_err, 1'b1);
    check("ill_wen0", {wen2, wen1, wen0}, 3'b000);
    tick();
    check("ill_drop_off", drop_err, 1'b0);
    check("ill_wen1", {wen2, wen1, wen0}, 3'b000);
    tick();
    check("ill_wen2", {wen2, wen1, wen0}, 3'b000);
    check("ill_ready_after", in_ready, 1'b1);

    // Concurrent: chans 0,1,2 on consecutive edges give staggered strobes.
    exp_wen = '{3'b001, 3'b010, 3'b100, 3'b000};
    in_valid = 1'b1; in_chan = 2'd0; in_data = 8'h10;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_chan  = 2'(i + 1);
      in_data  = 8'(8'h20 + 8'(i) * 8'h10);
      in_valid = (i < 2);
      tick();
      check($sformatf("conc_wen_%0d", i), {wen2, wen1, wen0}, exp_wen[i]);
    end
    in_valid = 1'b0;
    check("conc_d0", data0, 8'h10);
    check("conc_d1", data1, 8'h20);
    check("conc_d2", data2, 8'h30);

    // Reset with two bytes queued on chan 1.
    freeze = 1'b1; in_valid = 1'b1; in_chan = 2'd1; in_data = 8'hC1;
    tick();
    in_data = 8'hC2;
    tick();
    in_valid = 1'b0; freeze = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_wen",   {wen2, wen1, wen0}, 3'b000);
    check("rst2_data0", data0, 8'h00);
    check("rst2_data1", data1, 8'h00);
    check("rst2_data2", data2, 8'h00);
    check("rst2_drop",  drop_err, 1'b0);
    check("rst2_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst2_quiet_%0d", i), {wen2, wen1, wen0}, 3'b000);
    end

`ifdef PART2_WEN_DRIVER_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stats_rst", wr_count0, 16'h0000);
    in_valid = 1'b1; in_chan = 2'd0; in_data = 8'h5A;
    for (int i = 0; i < 65537; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("stats_wrap", wr_count0, 16'h0001);
    check("stats_c1",   wr_count1, 16'h0000);
    check("stats_c2",   wr_count2, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
